// File: rtl/transpose_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_pkg
//  Description : Shared types and default sizes for the transpose datapath
//                (collector and transpose fifo).
//  Revision    : 1.0 - initial release
// ============================================================================
package transpose_pkg;

    // Default geometry shared by every block in the transpose path
    localparam int c_DEFAULT_DEPTH = 8;
    localparam int c_DEFAULT_BITS  = 64;

    // Collector state: FILL gathers words, HOLD presents the finished vector
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } tc_state_t;

endpackage : transpose_pkg
`default_nettype wire

// File: rtl/transpose_collector.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_collector
//  Description : Serial-to-parallel collector. Gathers DEPTH words of BITS
//                width from a valid/ready stream (first word at index 0) and
//                presents them as one vector under a second valid/ready
//                handshake. A flush closes a partial, zero-padded vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module transpose_collector
    import transpose_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int BITS  = c_DEFAULT_BITS,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] q [DEPTH-1:0],
    output logic [CW-1:0]   out_count
);

    tc_state_t       r_state;
    tc_state_t       w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_fill_total;
    logic [BITS-1:0] r_data     [DEPTH-1:0];
    logic [BITS-1:0] w_data_nxt [DEPTH-1:0];
    logic            w_hold;
    logic            w_accept;
    logic            w_release;

    // Handshakes: while holding, input readiness follows out_ready so a new
    // vector can start in the same cycle the old one is taken.
    always_comb begin
        w_hold    = (r_state == HOLD);
        out_valid = w_hold;
        in_ready  = w_hold ? out_ready : 1'b1;
        w_accept  = in_valid && in_ready;
        w_release = w_hold && out_ready;
        out_count = w_hold ? r_count : '0;
    end

    // Vector output comes straight from the storage registers
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q[i] = r_data[i];
        end
    end

    // Next-state, fill count and storage update
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_data_nxt   = r_data;
        w_fill_total = r_count + CW'(w_accept);

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (r_count == CW'(i)) begin
                            w_data_nxt[i] = in_data;
                        end
                    end
                    w_count_nxt = w_fill_total;
                end
                // Close on the last word, or on flush when anything is held
                // (a word accepted alongside the flush counts).
                if ((w_accept && (r_count == CW'(DEPTH - 1))) ||
                    (flush && (w_fill_total != '0))) begin
                    w_state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (w_release) begin
                    // Clearing every entry keeps unused slots at zero, so a
                    // later flushed vector is zero-padded for free.
                    for (int i = 0; i < DEPTH; i++) begin
                        w_data_nxt[i] = '0;
                    end
                    if (w_accept) begin
                        w_data_nxt[0] = in_data;
                    end
                    w_count_nxt = CW'(w_accept);
                    w_state_nxt = FILL;
                end
            end

            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // State, count and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

endmodule : transpose_collector
`default_nettype wire

// File: tb/tb_transpose_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transpose_collector
//  Description : Self-checking bench for transpose_collector. A queue-based
//                reference model predicts vectors; a negedge monitor compares
//                the DUT outputs against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transpose_collector;
    import transpose_pkg::*;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] q [DEPTH-1:0];
    logic [CW-1:0]   out_count;

    transpose_collector #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .out_count (out_count)
    );

    initial forever #5 clk = ~clk;

    // Reference model: words collected so far, vectors awaiting release
    typedef struct {
        logic [BITS-1:0] w [DEPTH];
        int              n;
    } vec_t;

    vec_t            exp_q [$];
    logic [BITS-1:0] part  [$];
    bit              m_hold  = 1'b0;
    bit              started = 1'b0;
    int              n_chk = 0;
    int              n_pass = 0;
    int              n_acc = 0;
    int              n_assert_fail = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus; the model advances on the same edge
    task automatic cycle(input bit v, input logic [BITS-1:0] d,
                         input bit f, input bit ordy);
        bit   was_hold;
        bit   acc;
        vec_t e;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        was_hold = m_hold;
        acc      = v && (!was_hold || ordy);
        if (was_hold && ordy) m_hold = 1'b0;
        if (acc) begin
            part.push_back(d);
            n_acc++;
        end
        if (!was_hold && (part.size() == DEPTH || (f && part.size() > 0))) begin
            for (int i = 0; i < DEPTH; i++) e.w[i] = (i < part.size()) ? part[i] : '0;
            e.n = part.size();
            exp_q.push_back(e);
            part.delete();
            m_hold = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        part.delete();
        exp_q.delete();
        m_hold  = 1'b0;
        started = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare handshakes and vector contents every cycle
    always @(negedge clk) begin
        bit   er;
        bit   ok;
        int   bad;
        vec_t e;
        if (started && !rst) begin
            er = !m_hold || out_ready;
            chk(in_ready === er, "in_ready", {63'b0, in_ready}, {63'b0, er});
            chk(out_valid === m_hold, "out_valid", {63'b0, out_valid}, {63'b0, m_hold});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_vector", {60'b0, out_count}, '0);
                end else begin
                    e   = exp_q[0];
                    ok  = 1'b1;
                    bad = 0;
                    for (int i = 0; i < DEPTH; i++)
                        if (ok && q[i] !== e.w[i]) begin ok = 1'b0; bad = i; end
                    chk(ok, "q_hold", q[bad], e.w[bad]);
                    chk(out_count === CW'(e.n), "out_count", {60'b0, out_count}, BITS'(e.n));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk(out_count === '0, "out_count_idle", {60'b0, out_count}, '0);
                ok  = 1'b1;
                bad = 0;
                for (int i = 0; i < DEPTH; i++)
                    if (ok && q[i] !== ((i < part.size()) ? part[i] : '0)) begin
                        ok = 1'b0; bad = i;
                    end
                chk(ok, "q_fill", q[bad], (bad < part.size()) ? part[bad] : '0);
            end
        end
    end

    // Structural invariants
    logic [BITS*DEPTH-1:0] q_flat;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) q_flat[i*BITS +: BITS] = q[i];
    end

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        (dut.r_state == FILL) |-> (dut.r_count <= CW'(DEPTH - 1)))
        else begin n_assert_fail++; $display("FAIL a_count_range: count %0d", dut.r_count); end

    a_valid_count: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_count != '0))
        else begin n_assert_fail++; $display("FAIL a_valid_count: out_count 0 while valid"); end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(q_flat) && $stable(out_count)))
        else begin n_assert_fail++; $display("FAIL a_hold_stable: output changed while stalled"); end

    initial begin
        logic [BITS-1:0] a, b, c;
        int guard;

        do_reset();
        cycle(0, '0, 0, 0);

        // Basic fill 1..8, then backpressure with word 9 waiting
        for (int i = 1; i <= DEPTH; i++) cycle(1, BITS'(i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, BITS'(9), 0, 0);
        cycle(1, BITS'(9), 0, 1);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);

        // Back-to-back stream of 24 words
        for (int i = 0; i < 24; i++) cycle(1, BITS'(i), 0, 1);
        cycle(0, '0, 0, 1);

        // Flush after three words, flush with the third word, flush when empty
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        cycle(1, a, 0, 0); cycle(1, b, 0, 0); cycle(1, c, 0, 0);
        cycle(0, '0, 1, 0); cycle(0, '0, 0, 0); cycle(0, '0, 0, 1);
        cycle(1, a, 0, 0); cycle(1, b, 0, 0); cycle(1, c, 1, 0);
        cycle(0, '0, 0, 0); cycle(0, '0, 0, 1);
        cycle(0, '0, 1, 0); cycle(0, '0, 1, 1); cycle(0, '0, 0, 0);

        // Reset mid-fill and mid-hold
        for (int i = 0; i < 5; i++) cycle(1, BITS'(100 + i), 0, 0);
        do_reset();
        cycle(0, '0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, BITS'(200 + i), 0, 0);
        cycle(0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, BITS'(300 + i), 0, 0);
        cycle(0, '0, 0, 0);
        do_reset();
        cycle(0, '0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, BITS'(400 + i), 0, 0);
        cycle(0, '0, 0, 1);

        // Randomised traffic
        guard = 0;
        while (n_acc < 10300 && guard < 40000) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom},
                  ($urandom % 16) == 0, ($urandom % 3) != 0);
            guard++;
        end
        chk(guard < 40000, "random_budget", BITS'(guard), BITS'(40000));

        // Drain anything still pending
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 1);
        @(negedge clk);
        #1;
        chk(exp_q.size() == 0, "drain", BITS'(exp_q.size()), '0);
        chk(n_assert_fail == 0, "assertions", BITS'(n_assert_fail), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_transpose_collector
`default_nettype wire
